csr_access_unit: RTL

Initiator side of the CSR read/write interface. Sits in the execute stage between the instruction decoder and the CSR register file. Accepts one decoded Zicsr instruction at a time and sequences a read strobe, then an optional write strobe, toward the register file. Returns the old CSR value, or an illegal-instruction flag, to the pipeline through a valid/ready handshake.

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_access_unit_if.sv | 53 +++++
 rtl/csr_wdata_alu.sv | 30 +++
 rtl/csr_access_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg
// Shared definitions for the CSR access path: Zicsr funct3 encodings,
// privilege levels, the access-unit FSM state type and the internal
// read-modify-write operation codes used by the write-data merge.
// No ports (package).

package csr_pkg;

    // Zicsr funct3 encodings as they arrive from the decoder
    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    // Privilege levels; encoding 10 is reserved
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Merge operation, shared by register and immediate forms
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } csr_state_e;

    // Swap forms always write; set/clear forms write only with a nonzero source
    function automatic logic has_write_intent(input logic [2:0] funct3,
                                              input logic       src_zero);
        return (funct3[1:0] == OP_RW) || !src_zero;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// csr_access_unit_if
// Bundles the three handshakes of the CSR access unit:
//   req_*  decoded Zicsr instruction from the decoder (valid/ready)
//   rsp_*  old CSR value / illegal flag back to the pipeline (valid/ready)
//   csr_*  read/write strobes toward the CSR register file
// Modports: master = the access unit, slave = its environment
// (decoder, pipeline and register file).

interface csr_access_unit_if #(
    parameter int C_XLEN = 32
);

    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        req_funct3_i;
    logic [11:0]       req_addr_i;
    logic [C_XLEN-1:0] req_rs1_data_i;
    logic [4:0]        req_zimm_i;
    logic              req_src_zero_i;
    logic [1:0]        req_priv_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [C_XLEN-1:0] rsp_rd_data_o;
    logic              rsp_illegal_o;

    logic              csr_rd_en_o;
    logic              csr_wr_en_o;
    logic [11:0]       csr_addr_o;
    logic [C_XLEN-1:0] csr_wr_data_o;
    logic [C_XLEN-1:0] csr_rd_data_i;

    modport master (
        input  req_valid_i, req_funct3_i, req_addr_i, req_rs1_data_i,
               req_zimm_i, req_src_zero_i, req_priv_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rd_data_o, rsp_illegal_o,
        input  rsp_ready_i,
        output csr_rd_en_o, csr_wr_en_o, csr_addr_o, csr_wr_data_o,
        input  csr_rd_data_i
    );

    modport slave (
        output req_valid_i, req_funct3_i, req_addr_i, req_rs1_data_i,
               req_zimm_i, req_src_zero_i, req_priv_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rd_data_o, rsp_illegal_o,
        output rsp_ready_i,
        input  csr_rd_en_o, csr_wr_en_o, csr_addr_o, csr_wr_data_o,
        output csr_rd_data_i
    );

endinterface

// File: rtl/csr_wdata_alu.sv
// csr_wdata_alu
// Combinational merge of the old CSR value with the source operand.
// Ports:
//   op        merge operation (OP_RW / OP_RS / OP_RC)
//   old_value value read from the CSR
//   src       rs1 data or zero-extended immediate
//   wr_data   value to write back
// Pure bitwise logic, no carries.

module csr_wdata_alu
    import csr_pkg::*;
#(
    parameter int C_XLEN = 32
) (
    input  logic [1:0]        op,
    input  logic [C_XLEN-1:0] old_value,
    input  logic [C_XLEN-1:0] src,
    output logic [C_XLEN-1:0] wr_data
);

    always_comb begin
        wr_data = src;
        case (op)
            OP_RS:   wr_data = old_value | src;
            OP_RC:   wr_data = old_value & ~src;
            default: wr_data = src;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit
// Initiator side of the CSR read/write interface. Takes one decoded Zicsr
// instruction at a time, issues a read strobe, then an optional write
// strobe, and returns the old CSR value or an illegal flag.
// Ports:
//   clk_i     clock
//   resetb_i  asynchronous active-low reset
//   clk_en_i  global clock enable; low freezes all state and strobes
//   bus       csr_access_unit_if.master (req / rsp / csr groups)
// Configuration:
//   MERLIN_CSR_PRIV_CHECK_EN  when defined, accesses with addr[9:8] above
//                             the current privilege are illegal.

module csr_access_unit
    import csr_pkg::*;
#(
    parameter int C_XLEN = 32
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    csr_access_unit_if.master bus
);

    csr_state_e        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [C_XLEN-1:0] src_q, src_d;
    logic              write_q, write_d;
    logic [11:0]       addr_q, addr_d;
    logic [C_XLEN-1:0] old_q, old_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [C_XLEN-1:0] wr_data_q, wr_data_d;
    logic              valid_q, valid_d;
    logic              illegal_q, illegal_d;

    logic [1:0]        req_op;
    logic              bad_funct3;
    logic [C_XLEN-1:0] req_src;
    logic              req_write;
    logic              priv_fault;
    logic              req_illegal;
    logic [C_XLEN-1:0] alu_wr_data;

`ifdef MERLIN_CSR_PRIV_CHECK_EN
    assign priv_fault = bus.req_addr_i[9:8] > bus.req_priv_i;
`else
    logic unused_priv;
    assign unused_priv = ^bus.req_priv_i;
    assign priv_fault  = 1'b0;
`endif

    // Decode the offered instruction: merge op, source operand, write intent
    // and whether it must be rejected before any strobe is issued.
    always_comb begin
        req_op     = OP_RW;
        bad_funct3 = 1'b0;
        case (bus.req_funct3_i)
            CSR_RW, CSR_RWI: req_op = OP_RW;
            CSR_RS, CSR_RSI: req_op = OP_RS;
            CSR_RC, CSR_RCI: req_op = OP_RC;
            default:         bad_funct3 = 1'b1;
        endcase
        req_src     = bus.req_funct3_i[2] ? {{(C_XLEN-5){1'b0}}, bus.req_zimm_i}
                                          : bus.req_rs1_data_i;
        req_write   = has_write_intent(bus.req_funct3_i, bus.req_src_zero_i);
        req_illegal = bad_funct3
                    || (req_write && (bus.req_addr_i[11:10] == 2'b11))
                    || priv_fault;
    end

    // The merge sees the live read data during READ so the write value is
    // ready to be registered on the same edge that leaves READ.
    csr_wdata_alu #(
        .C_XLEN    (C_XLEN)
    ) u_wdata_alu (
        .op        (op_q),
        .old_value (bus.csr_rd_data_i),
        .src       (src_q),
        .wr_data   (alu_wr_data)
    );

    // Next-state and next-output logic. Every output is a flop, so each
    // strobe/valid is set on the transition into the state that owns it.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        write_d   = write_q;
        addr_d    = addr_q;
        old_d     = old_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    old_d = '0;
                    if (req_illegal) begin
                        state_d   = RESP;
                        valid_d   = 1'b1;
                        illegal_d = 1'b1;
                    end else begin
                        state_d   = READ;
                        op_d      = req_op;
                        src_d     = req_src;
                        write_d   = req_write;
                        addr_d    = bus.req_addr_i;
                        rd_en_d   = 1'b1;
                        illegal_d = 1'b0;
                    end
                end
            end
            READ: begin
                old_d = bus.csr_rd_data_i;
                if (write_q) begin
                    state_d   = WRITE;
                    wr_en_d   = 1'b1;
                    wr_data_d = alu_wr_data;
                end else begin
                    state_d = RESP;
                    valid_d = 1'b1;
                end
            end
            WRITE: begin
                state_d = RESP;
                valid_d = 1'b1;
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight access, clk_en_i freezes it.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
        end else if (clk_en_i) begin
            state_q <= state_d;
        end
    end

    // Latched request fields and registered outputs.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            op_q      <= OP_RW;
            src_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            old_q     <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (clk_en_i) begin
            op_q      <= op_d;
            src_q     <= src_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            old_q     <= old_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.req_ready_o   = (state_q == IDLE);
    assign bus.rsp_valid_o   = valid_q;
    assign bus.rsp_rd_data_o = old_q;
    assign bus.rsp_illegal_o = illegal_q;
    assign bus.csr_rd_en_o   = rd_en_q;
    assign bus.csr_wr_en_o   = wr_en_q;
    assign bus.csr_addr_o    = addr_q;
    assign bus.csr_wr_data_o = wr_data_q;

endmodule
